// File: rtl/npu_pkg.sv
// ============================================================================
//  Module      : npu_pkg
//  Description : Shared types and helpers for the NPU convolution scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package npu_pkg;

    localparam int CONV_XLEN = 32;

    typedef logic [CONV_XLEN-1:0] cfg_word_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT_WB = 3'd3,
        S_ERR     = 3'd4
    } conv_sched_state_e;

    typedef struct packed {
        cfg_word_t   kernel_baseaddr;
        cfg_word_t   feature_baseaddr;
        cfg_word_t   output_baseaddr;
        cfg_word_t   feature_width;
        cfg_word_t   feature_height;
        cfg_word_t   feature_chin;
        cfg_word_t   feature_chout;
        cfg_word_t   output_width;
        cfg_word_t   output_height;
        logic [7:0]  kernel_size;
        logic [7:0]  stride;
        logic [7:0]  padding;
        logic        has_bias;
        logic        has_relu;
    } conv_cfg_t;

    // Output extent (in + 2p - k) / s + 1; zero when the window cannot fit.
    function automatic logic [CONV_XLEN+1:0] conv_out_dim(
        input cfg_word_t  in_dim,
        input logic [7:0] k,
        input logic [7:0] s,
        input logic [7:0] p
    );
        logic [CONV_XLEN+1:0] span;
        logic [CONV_XLEN+1:0] kk;
        logic [CONV_XLEN+1:0] ss;
        span = (CONV_XLEN+2)'(in_dim) + (CONV_XLEN+2)'({p, 1'b0});
        kk   = (CONV_XLEN+2)'(k);
        ss   = (CONV_XLEN+2)'(s);
        if (ss == '0 || kk > span) begin
            return '0;
        end
        return (span - kk) / ss + (CONV_XLEN+2)'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_loop_ctr.sv
// ============================================================================
//  Module      : conv_loop_ctr
//  Description : Wrap counter for one loop level; carry fires on the wrapping step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_loop_ctr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_last,
    output logic [WIDTH-1:0] o_count,
    output logic             o_carry
);

    logic [WIDTH-1:0] r_count;

    assign o_count = r_count;
    assign o_carry = i_inc && (r_count == i_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= o_carry ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv_scheduler.sv
// ============================================================================
//  Module      : conv_scheduler
//  Description : Convolution loop-nest sequencer issuing one operand beat per MAC.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_scheduler
    import npu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] kernel_baseaddr,
    input  logic [XLEN-1:0] feature_baseaddr,
    input  logic [XLEN-1:0] output_baseaddr,
    input  logic [XLEN-1:0] feature_width,
    input  logic [XLEN-1:0] feature_height,
    input  logic [XLEN-1:0] feature_chin,
    input  logic [XLEN-1:0] feature_chout,
    input  logic [XLEN-1:0] output_width,
    input  logic [XLEN-1:0] output_height,
    input  logic [7:0]      kernel_size,
    input  logic [7:0]      stride,
    input  logic [7:0]      padding,
    input  logic            has_bias,
    input  logic            has_relu,
    output logic            running,
    output logic            conv_done,
    output logic            exception,
    output logic            beat_valid,
    input  logic            beat_ready,
    output logic [XLEN-1:0] feat_addr,
    output logic [XLEN-1:0] kern_addr,
    output logic            pad_zero,
    output logic            acc_first,
    output logic            acc_last,
    output logic [XLEN-1:0] out_addr,
    output logic            bias_en,
    output logic            relu_en,
    input  logic            wb_done
);

    localparam int              c_sw  = XLEN + 2;
    localparam logic [XLEN-1:0] c_one = XLEN'(1);

    conv_sched_state_e r_state, w_state_next;
    conv_cfg_t         r_cfg;

    logic r_running, r_conv_done, r_exception;
    logic r_beat_valid, r_pad_zero, r_acc_first, r_acc_last;
    logic [XLEN-1:0] r_feat_addr, r_kern_addr, r_out_addr;
    logic [XLEN-1:0] r_kern_ptr, r_kern_base, r_out_ptr;

    logic w_start_acc, w_accept, w_load, w_cfg_err, w_run_end;

    logic [XLEN-1:0] w_fb, w_fw, w_fh;
    logic [XLEN-1:0] w_cin_m1, w_cout_m1, w_ow_m1, w_oh_m1;
    logic [7:0]      w_k_m1;

    logic [7:0]      w_kx_cnt, w_ky_cnt;
    logic [XLEN-1:0] w_ic_cnt, w_ox_cnt, w_oy_cnt, w_oc_cnt;
    logic            w_kx_carry, w_ky_carry, w_ic_carry, w_ox_carry, w_oy_carry, w_oc_carry;

    logic [c_sw-1:0] w_iy, w_ix, w_span_w, w_span_h;
    logic [XLEN-1:0] w_feat;
    logic            w_pad, w_first;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_accept    = r_beat_valid && beat_ready;

    assign w_fb      = XLEN'(r_cfg.feature_baseaddr);
    assign w_fw      = XLEN'(r_cfg.feature_width);
    assign w_fh      = XLEN'(r_cfg.feature_height);
    assign w_k_m1    = r_cfg.kernel_size - 8'd1;
    assign w_cin_m1  = XLEN'(r_cfg.feature_chin) - c_one;
    assign w_cout_m1 = XLEN'(r_cfg.feature_chout) - c_one;
    assign w_ow_m1   = XLEN'(r_cfg.output_width) - c_one;
    assign w_oh_m1   = XLEN'(r_cfg.output_height) - c_one;

    // Loop nest, innermost first; each level steps on the carry of the one inside it.
    conv_loop_ctr #(.WIDTH(8)) u_kx (.clk(clk), .rst_n(rst_n), .i_clr(w_start_acc), .i_inc(w_load),
        .i_last(w_k_m1), .o_count(w_kx_cnt), .o_carry(w_kx_carry));
    conv_loop_ctr #(.WIDTH(8)) u_ky (.clk(clk), .rst_n(rst_n), .i_clr(w_start_acc), .i_inc(w_kx_carry),
        .i_last(w_k_m1), .o_count(w_ky_cnt), .o_carry(w_ky_carry));
    conv_loop_ctr #(.WIDTH(XLEN)) u_ic (.clk(clk), .rst_n(rst_n), .i_clr(w_start_acc), .i_inc(w_ky_carry),
        .i_last(w_cin_m1), .o_count(w_ic_cnt), .o_carry(w_ic_carry));
    conv_loop_ctr #(.WIDTH(XLEN)) u_ox (.clk(clk), .rst_n(rst_n), .i_clr(w_start_acc), .i_inc(w_ic_carry),
        .i_last(w_ow_m1), .o_count(w_ox_cnt), .o_carry(w_ox_carry));
    conv_loop_ctr #(.WIDTH(XLEN)) u_oy (.clk(clk), .rst_n(rst_n), .i_clr(w_start_acc), .i_inc(w_ox_carry),
        .i_last(w_oh_m1), .o_count(w_oy_cnt), .o_carry(w_oy_carry));
    conv_loop_ctr #(.WIDTH(XLEN)) u_oc (.clk(clk), .rst_n(rst_n), .i_clr(w_start_acc), .i_inc(w_oy_carry),
        .i_last(w_cout_m1), .o_count(w_oc_cnt), .o_carry(w_oc_carry));

    // Counters describe the beat about to be loaded into the output register.
    assign w_iy = c_sw'(w_oy_cnt) * c_sw'(r_cfg.stride) + c_sw'(w_ky_cnt) - c_sw'(r_cfg.padding);
    assign w_ix = c_sw'(w_ox_cnt) * c_sw'(r_cfg.stride) + c_sw'(w_kx_cnt) - c_sw'(r_cfg.padding);
    assign w_pad = w_iy[c_sw-1] || w_ix[c_sw-1] || (w_iy >= c_sw'(w_fh)) || (w_ix >= c_sw'(w_fw));
    assign w_feat = w_fb + (w_ic_cnt * w_fh + w_iy[XLEN-1:0]) * w_fw + w_ix[XLEN-1:0];
    assign w_first = (w_ic_cnt == '0) && (w_ky_cnt == '0) && (w_kx_cnt == '0);
    // After the last pixel is loaded every pixel counter has wrapped back to zero.
    assign w_run_end = (w_ox_cnt == '0) && (w_oy_cnt == '0) && (w_oc_cnt == '0);

    assign w_span_w = c_sw'(w_fw) + c_sw'({r_cfg.padding, 1'b0});
    assign w_span_h = c_sw'(w_fh) + c_sw'({r_cfg.padding, 1'b0});
    assign w_cfg_err =
        (r_cfg.kernel_size == '0) || (r_cfg.stride == '0) ||
        (r_cfg.feature_width == '0) || (r_cfg.feature_height == '0) ||
        (r_cfg.feature_chin == '0) || (r_cfg.feature_chout == '0) ||
        (r_cfg.output_width == '0) || (r_cfg.output_height == '0) ||
        (c_sw'(r_cfg.kernel_size) > w_span_w) || (c_sw'(r_cfg.kernel_size) > w_span_h) ||
        ((CONV_XLEN+2)'(r_cfg.output_width) !=
            conv_out_dim(r_cfg.feature_width, r_cfg.kernel_size, r_cfg.stride, r_cfg.padding)) ||
        ((CONV_XLEN+2)'(r_cfg.output_height) !=
            conv_out_dim(r_cfg.feature_height, r_cfg.kernel_size, r_cfg.stride, r_cfg.padding));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_cfg_err) begin
                    w_state_next = S_ERR;
                end else begin
                    w_state_next = S_ISSUE;
                    w_load       = 1'b1;
                end
            end
            S_ISSUE: begin
                if (w_accept) begin
                    if (r_acc_last) w_state_next = S_WAIT_WB;
                    else            w_load       = 1'b1;
                end
            end
            S_WAIT_WB: begin
                if (wb_done) begin
                    if (w_run_end) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_ISSUE;
                        w_load       = 1'b1;
                    end
                end
            end
            S_ERR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg       <= '0;
            r_running   <= 1'b0;
            r_conv_done <= 1'b0;
            r_exception <= 1'b0;
        end else begin
            r_running <= (w_state_next != S_IDLE);
            if (w_start_acc) begin
                r_cfg <= '{
                    kernel_baseaddr:  cfg_word_t'(kernel_baseaddr),
                    feature_baseaddr: cfg_word_t'(feature_baseaddr),
                    output_baseaddr:  cfg_word_t'(output_baseaddr),
                    feature_width:    cfg_word_t'(feature_width),
                    feature_height:   cfg_word_t'(feature_height),
                    feature_chin:     cfg_word_t'(feature_chin),
                    feature_chout:    cfg_word_t'(feature_chout),
                    output_width:     cfg_word_t'(output_width),
                    output_height:    cfg_word_t'(output_height),
                    kernel_size:      kernel_size,
                    stride:           stride,
                    padding:          padding,
                    has_bias:         has_bias,
                    has_relu:         has_relu
                };
                r_conv_done <= 1'b0;
                r_exception <= 1'b0;
            end
            if (r_state == S_CHECK && w_cfg_err) r_exception <= 1'b1;
            if (r_state == S_WAIT_WB && wb_done && w_run_end) r_conv_done <= 1'b1;
        end
    end

    // Kernel pointer replays one filter per pixel and moves on when oc advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_valid <= 1'b0;
            r_feat_addr  <= '0;
            r_kern_addr  <= '0;
            r_out_addr   <= '0;
            r_pad_zero   <= 1'b0;
            r_acc_first  <= 1'b0;
            r_acc_last   <= 1'b0;
            r_kern_ptr   <= '0;
            r_kern_base  <= '0;
            r_out_ptr    <= '0;
        end else if (w_start_acc) begin
            r_kern_ptr  <= kernel_baseaddr;
            r_kern_base <= kernel_baseaddr;
            r_out_ptr   <= output_baseaddr;
        end else if (w_load) begin
            r_beat_valid <= 1'b1;
            r_feat_addr  <= w_feat;
            r_kern_addr  <= r_kern_ptr;
            r_out_addr   <= r_out_ptr;
            r_pad_zero   <= w_pad;
            r_acc_first  <= w_first;
            r_acc_last   <= w_ic_carry;
            if (w_oc_carry) begin
                r_kern_ptr  <= XLEN'(r_cfg.kernel_baseaddr);
                r_kern_base <= XLEN'(r_cfg.kernel_baseaddr);
            end else if (w_oy_carry) begin
                r_kern_ptr  <= r_kern_ptr + c_one;
                r_kern_base <= r_kern_ptr + c_one;
            end else if (w_ic_carry) begin
                r_kern_ptr <= r_kern_base;
            end else begin
                r_kern_ptr <= r_kern_ptr + c_one;
            end
            if (w_ic_carry) r_out_ptr <= r_out_ptr + c_one;
        end else if (w_accept) begin
            r_beat_valid <= 1'b0;
        end
    end

    assign running    = r_running;
    assign conv_done  = r_conv_done;
    assign exception  = r_exception;
    assign beat_valid = r_beat_valid;
    assign feat_addr  = r_feat_addr;
    assign kern_addr  = r_kern_addr;
    assign out_addr   = r_out_addr;
    assign pad_zero   = r_pad_zero;
    assign acc_first  = r_acc_first;
    assign acc_last   = r_acc_last;
    assign bias_en    = r_cfg.has_bias;
    assign relu_en    = r_cfg.has_relu;

endmodule

`default_nettype wire
